leaf_stream_arbiter: RTL and testbench

Parametrised egress stage for a leaf: buffers NUM_PORTS user valid/ack streams, arbitrates them round-robin under per-port credit flow control, and emits one packet per cycle onto the leaf-to-BFT packet bus. It generalises the fixed six-port user-to-interface path to any port count and adds three things that path lacks: a run-time destination table, per-port sequence numbering, and backpressure from both the credit return and the downstream ready.

---
 rtl/leaf_stream_arbiter.sv | 147 ++++++++++++++
 tb/tb_leaf_stream_arbiter.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/leaf_stream_arbiter.sv
// Leaf egress stage: per-port 2-deep input FIFOs, credit-gated round-robin
// arbitration, and a single registered packet output with downstream ready.
// Each packet carries a run-time destination from a small table plus a
// per-port wrapping sequence number.
module leaf_stream_arbiter #(
  parameter int NUM_PORTS             = 6,
  parameter int PAYLOAD_BITS          = 32,
  parameter int NUM_LEAF_BITS         = 5,
  parameter int NUM_PORT_BITS         = 4,
  parameter int NUM_ADDR_BITS         = 7,
  parameter int PACKET_BITS           = 49,
  parameter int CREDIT_BITS           = 8,
  parameter int INIT_CREDITS          = 128,
  parameter int FREESPACE_UPDATE_SIZE = 64
) (
  input  logic                              clk_user,
  input  logic                              reset,
  input  logic [NUM_PORTS*PAYLOAD_BITS-1:0] din_user2interface,
  input  logic [NUM_PORTS-1:0]              vld_user2interface,
  output logic [NUM_PORTS-1:0]              ack_interface2user,
  input  logic                              cfg_wr_en,
  input  logic [NUM_PORT_BITS-1:0]          cfg_port,
  input  logic [NUM_LEAF_BITS-1:0]          cfg_dst_leaf,
  input  logic [NUM_PORT_BITS-1:0]          cfg_dst_port,
  input  logic                              credit_vld,
  input  logic [NUM_PORT_BITS-1:0]          credit_port,
  output logic [PACKET_BITS-1:0]            dout_leaf_interface2bft,
  input  logic                              dout_ready
);

  // Two guard bits so a return on top of a near-full counter can be seen
  // before saturating.
  localparam int CW = CREDIT_BITS + 2;
  localparam logic [CW-1:0] CMAX = CW'((1 << CREDIT_BITS) - 1);
  localparam logic [CW-1:0] FUS  = CW'(FREESPACE_UPDATE_SIZE);

  logic [NUM_PORTS-1:0][1:0][PAYLOAD_BITS-1:0] mem;
  logic [NUM_PORTS-1:0]                        rd_ptr, wr_ptr;
  logic [NUM_PORTS-1:0][1:0]                   count;
  logic [NUM_PORTS-1:0][CREDIT_BITS-1:0]       credit;
  logic [NUM_PORTS-1:0][CW-1:0]                csum;
  logic [NUM_PORTS-1:0][NUM_ADDR_BITS-1:0]     seq;
  logic [NUM_PORTS-1:0][NUM_LEAF_BITS-1:0]     tbl_leaf;
  logic [NUM_PORTS-1:0][NUM_PORT_BITS-1:0]     tbl_port;
  logic [NUM_PORTS-1:0]                        push, grant, ret, elig;
  logic [NUM_PORTS-1:0]                        hi_oh, lo_oh;
  logic                                        found_hi, found_lo;
  logic [NUM_PORT_BITS-1:0]                    last_grant, gidx_d;
  logic [PACKET_BITS-1:0]                      pkt, pkt_d;
  logic                                        loadable;

  assign loadable                = ~pkt[PACKET_BITS-1] | dout_ready;
  assign dout_leaf_interface2bft = pkt;

  for (genvar i = 0; i < NUM_PORTS; i++) begin : g_port
    assign ack_interface2user[i] = reset & (count[i] != 2'd2);
    assign push[i] = vld_user2interface[i] & ack_interface2user[i];
    assign elig[i] = (count[i] != 2'd0) && (credit[i] != '0);
    // Out-of-range credit_port never matches any port, so it is dropped.
    assign ret[i]  = credit_vld && (credit_port == NUM_PORT_BITS'(i));
  end

  // Next credit value: return adds, grant consumes one; clipped at all-ones.
  always_comb begin
    for (int i = 0; i < NUM_PORTS; i++)
      csum[i] = {2'b00, credit[i]} + (ret[i] ? FUS : '0)
              - {{(CW-1){1'b0}}, grant[i]};
  end

  // Round-robin pick: lowest eligible port above last_grant, else wrap to
  // the lowest eligible port overall.
  always_comb begin
    hi_oh    = '0;
    lo_oh    = '0;
    found_hi = 1'b0;
    found_lo = 1'b0;
    for (int j = 0; j < NUM_PORTS; j++) begin
      if (!found_hi && elig[j] && (NUM_PORT_BITS'(j) > last_grant)) begin
        hi_oh[j] = 1'b1;
        found_hi = 1'b1;
      end
      if (!found_lo && elig[j]) begin
        lo_oh[j] = 1'b1;
        found_lo = 1'b1;
      end
    end
    grant = '0;
    if (loadable) grant = found_hi ? hi_oh : lo_oh;
  end

  // Packet mux: granted port's head word, or the old packet with valid cleared.
  always_comb begin
    pkt_d  = {1'b0, pkt[PACKET_BITS-2:0]};
    gidx_d = last_grant;
    for (int j = 0; j < NUM_PORTS; j++) begin
      if (grant[j]) begin
        pkt_d  = {1'b1, tbl_leaf[j], tbl_port[j], seq[j], mem[j][rd_ptr[j]]};
        gidx_d = NUM_PORT_BITS'(j);
      end
    end
  end

  // Per-port state: FIFO, credits, sequence counter and destination entry.
  always_ff @(posedge clk_user) begin
    if (!reset) begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        count[i]    <= 2'd0;
        rd_ptr[i]   <= 1'b0;
        wr_ptr[i]   <= 1'b0;
        credit[i]   <= CREDIT_BITS'(INIT_CREDITS);
        seq[i]      <= '0;
        tbl_leaf[i] <= '0;
        tbl_port[i] <= NUM_PORT_BITS'(i);
      end
    end else begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        if (push[i]) begin
          mem[i][wr_ptr[i]] <= din_user2interface[i*PAYLOAD_BITS +: PAYLOAD_BITS];
          wr_ptr[i]         <= ~wr_ptr[i];
        end
        if (grant[i]) begin
          rd_ptr[i] <= ~rd_ptr[i];
          seq[i]    <= seq[i] + NUM_ADDR_BITS'(1);
        end
        count[i]  <= count[i] + {1'b0, push[i]} - {1'b0, grant[i]};
        credit[i] <= (csum[i] > CMAX) ? CMAX[CREDIT_BITS-1:0]
                                      : csum[i][CREDIT_BITS-1:0];
        if (cfg_wr_en && (cfg_port == NUM_PORT_BITS'(i))) begin
          tbl_leaf[i] <= cfg_dst_leaf;
          tbl_port[i] <= cfg_dst_port;
        end
      end
    end
  end

  // Output register and arbitration pointer; both frozen while stalled.
  always_ff @(posedge clk_user) begin
    if (!reset) begin
      pkt        <= '0;
      last_grant <= NUM_PORT_BITS'(NUM_PORTS - 1);
    end else if (loadable) begin
      pkt        <= pkt_d;
      last_grant <= gidx_d;
    end
  end

endmodule

// File: tb/tb_leaf_stream_arbiter.sv
// Bench for leaf_stream_arbiter: a directed vector table, hand-written
// corner sequences, and a randomized run, all compared every cycle against a
// queue-based behavioural model of the egress stage.
module tb_leaf_stream_arbiter;
  localparam int NP = 6;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [NP*32-1:0] din;
  logic [NP-1:0] vld, ack;
  logic          cfg_wr_en, credit_vld, rdy;
  logic [3:0]    cfg_port, cfg_dport, credit_port;
  logic [4:0]    cfg_leaf;
  logic [48:0]   dout;

  always #5 clk = ~clk;

  leaf_stream_arbiter #(.NUM_PORTS(NP)) dut (
    .clk_user(clk), .reset(rst_n),
    .din_user2interface(din), .vld_user2interface(vld), .ack_interface2user(ack),
    .cfg_wr_en(cfg_wr_en), .cfg_port(cfg_port), .cfg_dst_leaf(cfg_leaf),
    .cfg_dst_port(cfg_dport), .credit_vld(credit_vld), .credit_port(credit_port),
    .dout_leaf_interface2bft(dout), .dout_ready(rdy));

  int total = 0, bad = 0, cyc = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cycle %0d: got %h expected %h", nm, cyc, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [31:0] mq [NP][$];
  int          mcred [NP];
  int          mseq  [NP];
  int          mleaf [NP];
  int          mport [NP];
  int          mlast;
  logic [48:0] mout;

  task automatic model_step();
    int g;
    bit ld;
    bit acc [NP];
    logic [31:0] pay;
    if (!rst_n) begin
      for (int p = 0; p < NP; p++) begin
        mq[p].delete();
        mcred[p] = 128; mseq[p] = 0; mleaf[p] = 0; mport[p] = p;
      end
      mlast = NP - 1;
      mout  = '0;
      return;
    end
    for (int p = 0; p < NP; p++) acc[p] = vld[p] && (mq[p].size() < 2);
    ld = !mout[48] || rdy;
    g  = -1;
    if (ld)
      for (int k = 1; k <= NP; k++) begin
        int p;
        p = (mlast + k) % NP;
        if (g < 0 && mq[p].size() > 0 && mcred[p] > 0) g = p;
      end
    if (g >= 0) begin
      pay  = mq[g].pop_front();
      mout = {1'b1, 5'(mleaf[g]), 4'(mport[g]), 7'(mseq[g]), pay};
      mseq[g] = (mseq[g] + 1) % 128;
      mcred[g]--;
      mlast = g;
    end else if (ld) begin
      mout[48] = 1'b0;
    end
    for (int p = 0; p < NP; p++) if (acc[p]) mq[p].push_back(din[p*32 +: 32]);
    if (credit_vld && credit_port < NP) begin
      mcred[credit_port] += 64;
      if (mcred[credit_port] > 255) mcred[credit_port] = 255;
    end
    if (cfg_wr_en && cfg_port < NP) begin
      mleaf[cfg_port] = int'(cfg_leaf);
      mport[cfg_port] = int'(cfg_dport);
    end
  endtask

  // One clock: advance the model on the pre-edge inputs, then compare.
  task automatic tick();
    logic [NP-1:0] mack;
    model_step();
    @(posedge clk);
    #1;
    cyc++;
    for (int p = 0; p < NP; p++) mack[p] = rst_n && (mq[p].size() < 2);
    check("ack", 64'(ack), 64'(mack));
    check("dout", 64'(dout), 64'(mout));
  endtask

  task automatic idle_inputs();
    vld = '0; din = '0; cfg_wr_en = 0; cfg_port = '0; cfg_leaf = '0;
    cfg_dport = '0; credit_vld = 0; credit_port = '0; rdy = 1;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 0;
    tick();
    rst_n = 1;
  endtask

  typedef struct {
    logic          rst;
    logic [NP-1:0] vld;
    logic [31:0]   din0;
    logic          rdy;
    logic [NP-1:0] exp_ack;
    logic [48:0]   exp_dout;
  } vec_t;
  vec_t vecs [9];

  int nv;
  bit seen2;
  logic [48:0] held;

  initial begin
    vecs[0] = '{1'b0, 6'h00, 32'h0,         1'b1, 6'h00, 49'h0};
    vecs[1] = '{1'b1, 6'h00, 32'h0,         1'b1, 6'h3F, 49'h0};
    vecs[2] = '{1'b1, 6'h01, 32'hA5A5_0001, 1'b1, 6'h3F, 49'h0};
    vecs[3] = '{1'b1, 6'h00, 32'h0,         1'b1, 6'h3F, 49'h1_0000_A5A5_0001};
    vecs[4] = '{1'b1, 6'h00, 32'h0,         1'b1, 6'h3F, 49'h0_0000_A5A5_0001};
    vecs[5] = '{1'b1, 6'h01, 32'h0000_0011, 1'b0, 6'h3F, 49'h0_0000_A5A5_0001};
    vecs[6] = '{1'b1, 6'h00, 32'h0,         1'b0, 6'h3F, 49'h1_0001_0000_0011};
    vecs[7] = '{1'b1, 6'h00, 32'h0,         1'b0, 6'h3F, 49'h1_0001_0000_0011};
    vecs[8] = '{1'b1, 6'h00, 32'h0,         1'b1, 6'h3F, 49'h0_0001_0000_0011};

    idle_inputs();
    rst_n = 0;

    // Reset release, single word on port 0, hold and clear behaviour.
    for (int i = 0; i < 9; i++) begin
      rst_n = vecs[i].rst; vld = vecs[i].vld; din[31:0] = vecs[i].din0; rdy = vecs[i].rdy;
      tick();
      check($sformatf("vec%0d_ack", i), 64'(ack), 64'(vecs[i].exp_ack));
      check($sformatf("vec%0d_dout", i), 64'(dout), 64'(vecs[i].exp_dout));
    end

    // All ports streaming: strict 0..5 rotation, per-port seq counting up.
    do_reset();
    vld = '1;
    for (int p = 0; p < NP; p++) din[p*32 +: 32] = {8'(p), 24'(cyc)};
    tick();
    for (int n = 0; n < 12; n++) begin
      for (int p = 0; p < NP; p++) din[p*32 +: 32] = {8'(p), 24'(cyc)};
      tick();
      check("rr_valid", 64'(dout[48]), 64'd1);
      check("rr_port", 64'(dout[42:39]), 64'(n % NP));
      check("rr_seq", 64'(dout[38:32]), 64'(n / NP));
    end

    // Downstream stall for 5 cycles: packet frozen, FIFOs fill, acks drop.
    held = dout;
    rdy = 0;
    for (int n = 0; n < 5; n++) begin
      for (int p = 0; p < NP; p++) din[p*32 +: 32] = {8'(p), 24'(cyc)};
      tick();
      check("stall_hold", 64'(dout), 64'(held));
    end
    check("stall_ack", 64'(ack), 64'd0);
    rdy = 1;
    for (int n = 0; n < 20; n++) begin
      for (int p = 0; p < NP; p++) din[p*32 +: 32] = {8'(p), 24'(cyc)};
      tick();
    end

    // Port 3 drains its credits, stalls with a full FIFO, resumes on return.
    do_reset();
    vld = 6'h08;
    nv = 0;
    for (int n = 0; n < 140; n++) begin
      din[3*32 +: 32] = 32'(cyc);
      tick();
      if (dout[48]) nv++;
    end
    check("exh_count", 64'(nv), 64'd128);
    check("exh_ack3", 64'(ack[3]), 64'd0);
    credit_vld = 1; credit_port = 4'd3;
    tick();
    credit_vld = 0;
    tick();
    check("exh_resume_valid", 64'(dout[48]), 64'd1);
    check("exh_resume_port", 64'(dout[42:39]), 64'd3);
    check("exh_seq_wrap", 64'(dout[38:32]), 64'd0);

    // Saturation: two returns clip at 255, five grants, another return clips.
    do_reset();
    nv = 0;
    credit_vld = 1; credit_port = 4'd1;
    tick(); tick();
    credit_vld = 0;
    vld = 6'h02;
    for (int n = 0; n < 5; n++) begin din[63:32] = 32'(cyc); tick(); if (dout[48]) nv++; end
    vld = 0;
    tick(); if (dout[48]) nv++;
    credit_vld = 1;
    tick(); if (dout[48]) nv++;
    credit_vld = 0;
    vld = 6'h02;
    for (int n = 0; n < 270; n++) begin din[63:32] = 32'(cyc); tick(); if (dout[48]) nv++; end
    check("sat_count", 64'(nv), 64'd260);

    // Grant and return on the same port in one cycle: net +63.
    do_reset();
    nv = 0;
    vld = 6'h10;
    credit_port = 4'd4;
    for (int n = 0; n < 220; n++) begin
      credit_vld = (n == 10);
      din[4*32 +: 32] = 32'(cyc);
      tick();
      if (dout[48]) nv++;
    end
    credit_vld = 0;
    check("same_cycle_count", 64'(nv), 64'd192);

    // Destination table: port 2 rewritten, out-of-range index ignored.
    do_reset();
    cfg_wr_en = 1; cfg_port = 4'd2; cfg_leaf = 5'd17; cfg_dport = 4'd9;
    tick();
    cfg_port = 4'd6; cfg_leaf = 5'd3; cfg_dport = 4'd3;
    tick();
    cfg_wr_en = 0;
    vld = 6'h05;
    seen2 = 0;
    for (int n = 0; n < 8; n++) begin
      din[31:0]  = {8'h00, 24'(cyc)};
      din[95:64] = {8'h02, 24'(cyc)};
      tick();
      if (dout[48]) begin
        if (dout[31:24] == 8'h02) begin
          seen2 = 1;
          check("cfg_p2_dst", 64'({dout[47:43], dout[42:39]}), 64'({5'd17, 4'd9}));
        end else begin
          check("cfg_p0_dst", 64'({dout[47:43], dout[42:39]}), 64'd0);
        end
      end
    end
    check("cfg_seen_p2", 64'(seen2), 64'd1);

    // Reset in the middle of a stream wipes output and acks at that edge.
    vld = '1;
    for (int n = 0; n < 5; n++) begin
      for (int p = 0; p < NP; p++) din[p*32 +: 32] = $urandom;
      tick();
    end
    rst_n = 0;
    tick();
    check("midrst_dout", 64'(dout), 64'd0);
    check("midrst_ack", 64'(ack), 64'd0);
    rst_n = 1;
    for (int n = 0; n < 10; n++) tick();

    // Randomized traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      rst_n       = ($urandom_range(0, 199) != 0);
      vld         = 6'($urandom);
      for (int p = 0; p < NP; p++) din[p*32 +: 32] = $urandom;
      rdy         = ($urandom_range(0, 9) < 7);
      credit_vld  = ($urandom_range(0, 9) == 0);
      credit_port = 4'($urandom_range(0, 7));
      cfg_wr_en   = ($urandom_range(0, 19) == 0);
      cfg_port    = 4'($urandom_range(0, 7));
      cfg_leaf    = 5'($urandom);
      cfg_dport   = 4'($urandom);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
